// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive/transmit blocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int M = OVERSAMPLE_DEFAULT / 2 - 1;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int rate;
        rate = baud * oversample;
        return (clk_freq + rate / 2) / rate;
    endfunction

    function automatic int mid_point(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// rtl/uart_rx_frontend_if.sv - processor-side register view of the UART receiver
interface uart_rx_frontend_if;

    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    modport master (
        input  rd_ack,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output parity_err,
        output busy
    );

    modport slave (
        output rd_ack,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        input  busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - divide-by-DIV counter emitting a one-cycle oversample tick
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 16x oversampled 8N1 receiver; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk_50Mhz,
    input  logic                  rst_n,
    input  logic                  rx,
    uart_rx_frontend_if.master    bus
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int MID = mid_point(OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);

    logic            rx_meta_q;
    logic            rxs_q;
    logic            rxs_prev_q;
    rx_state_e       state_q,      state_d;
    logic [SW-1:0]   s_q,          s_d;
    logic [2:0]      bit_idx_q,    bit_idx_d;
    logic [1:0]      smp_q,        smp_d;
    logic [7:0]      shift_q,      shift_d;
    logic [7:0]      rx_data_q,    rx_data_d;
    logic            rx_valid_q,   rx_valid_d;
    logic            frame_err_q,  frame_err_d;
    logic            overrun_q,    overrun_d;
    logic            busy_q,       busy_d;
`ifdef UART_RX_PARITY_EN
    logic            parity_err_q, parity_err_d;
    logic            set_pe;
`endif

    logic tick;
    logic baud_clr;
    logic majority;
    logic mid_tick;
    logic last_tick;
    logic commit;
    logic set_fe;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk_50Mhz),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .tick  (tick)
    );

    // Two stored samples plus the live one form the three-sample vote ending at mid-bit.
    assign majority  = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs_q) | (smp_q[0] & rxs_q);
    assign mid_tick  = tick && (s_q == SW'(MID));
    assign last_tick = tick && (s_q == SW'(OVERSAMPLE - 1));

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        bit_idx_d   = bit_idx_q;
        smp_d       = smp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        baud_clr    = 1'b0;
        commit      = 1'b0;
        set_fe      = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
        set_pe       = 1'b0;
`endif

        if (tick) begin
            s_d   = last_tick ? '0 : s_q + SW'(1);
            smp_d = {smp_q[0], rxs_q};
        end

        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d  = START;
                    s_d      = '0;
                    baud_clr = 1'b1;
                end
            end
            START: begin
                if (mid_tick && majority) begin
                    state_d = IDLE;
                end else if (last_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (mid_tick) begin
                    shift_d = {majority, shift_q[7:1]};
                end
                if (last_tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_tick && (majority != ^shift_q)) begin
                    set_pe = 1'b1;
                end
                if (last_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (mid_tick) begin
                    if (majority) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acknowledge clears first so that a same-cycle set or commit takes priority.
        if (bus.rd_ack) begin
            rx_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
        if (commit) begin
            if (!rx_valid_q || bus.rd_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (set_fe) begin
            frame_err_d = 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        if (set_pe) begin
            parity_err_d = 1'b1;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= IDLE;
            s_q         <= '0;
            bit_idx_q   <= 3'd0;
            smp_q       <= 2'b11;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            state_q     <= state_d;
            s_q         <= s_d;
            bit_idx_q   <= bit_idx_d;
            smp_q       <= smp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule
